// File: rtl/isqrt_seq.sv
// -----------------------------------------------------------------------------
// isqrt_seq -- sequential unsigned fixed-point square root.
//
// Inverse of the approximate squarer on the shading path. The radicand carries
// the squarer's POST_SHIFT scaling, so the unit roots E = in_data << POST_SHIFT
// and returns the N-bit root in the original fixed-point format. It uses the
// restoring digit-by-digit method and produces one root bit per clock.
//
// Parameters:
//   N          root width; the radicand is 2N bits wide
//   POST_SHIFT left pre-shift applied to the radicand (must be even)
//   ITER       (2N+POST_SHIFT)/2 iterations, derived internally
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   radicand valid
//   in_ready   unit idle and able to accept a radicand
//   in_data    unsigned radicand, 2N bits
//   out_valid  result valid
//   out_ready  consumer accepts the result
//   out_root   floor(sqrt(in_data << POST_SHIFT)), saturated to N bits
//   out_sat    the true root did not fit in N bits
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. in_ready is high only in IDLE, and out_valid only in DONE; while
// out_valid is high, out_root/out_sat stay stable until out_ready is seen.
//
// Optional build macro ISQRT_EARLY_EXIT_EN: a leading-one detector skips the
// all-zero leading bit pairs of E, so the iteration count becomes p+1 (p =
// index of the highest nonzero bit pair, 1 iteration for a zero radicand).
// Results are bit-identical to the fixed-latency build.
// -----------------------------------------------------------------------------
module isqrt_seq #(
    parameter int N          = 16,
    parameter int POST_SHIFT = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2*N-1:0]   in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_root,
    output logic             out_sat
);

    localparam int EW   = 2*N + POST_SHIFT;  // extended radicand width
    localparam int ITER = EW / 2;            // root bits / iterations
    localparam int RW   = ITER + 2;          // remainder width
    localparam int CW   = $clog2(ITER + 1);  // iteration counter width

    if ((POST_SHIFT % 2) != 0) begin : g_bad_shift
        $error("isqrt_seq: POST_SHIFT must be even");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [EW-1:0]   ext_q, ext_d;
    logic [ITER-1:0] root_q, root_d;
    logic [RW-1:0]   rem_q, rem_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;
    logic [N-1:0]    out_root_q, out_root_d;
    logic            out_sat_q, out_sat_d;

    // Extended radicand and the values loaded at the accept edge.
    logic [EW-1:0]   e_in;
    logic [EW-1:0]   ext_init;
    logic [CW-1:0]   cnt_init;

    assign e_in = EW'(in_data) << POST_SHIFT;

`ifdef ISQRT_EARLY_EXIT_EN
    // Leading-one detector over bit pairs: the last hit in the ascending loop
    // is the highest nonzero pair. E is moved up so that pair sits at the top,
    // which is exactly where the fixed build would be after skipping the
    // leading zero pairs (those iterations only shift zeros into the root).
    int lod_p;
    int lod_sh;

    always_comb begin
        lod_p = 0;
        for (int i = 0; i < ITER; i++) begin
            if (e_in[2*i +: 2] != 2'b00) begin
                lod_p = i;
            end
        end
        lod_sh   = 2 * (ITER - 1 - lod_p);
        ext_init = e_in << lod_sh;
        cnt_init = CW'(lod_p + 1);
    end
`else
    always_comb begin
        ext_init = e_in;
        cnt_init = CW'(ITER);
    end
`endif

    // One restoring step: bring down the next bit pair, try {root, 01}.
    logic [RW-1:0]   rem_shift;
    logic [RW-1:0]   trial;
    logic [RW-1:0]   rem_step;
    logic [ITER-1:0] root_step;
    logic            sat_step;

    always_comb begin
        // The remainder never exceeds 2*root, so its top two bits are zero
        // before the shift and can be dropped.
        rem_shift = {rem_q[RW-3:0], ext_q[EW-1 -: 2]};
        trial     = {root_q, 2'b01};
        if (rem_shift >= trial) begin
            rem_step  = rem_shift - trial;
            root_step = {root_q[ITER-2:0], 1'b1};
        end else begin
            rem_step  = rem_shift;
            root_step = {root_q[ITER-2:0], 1'b0};
        end
        sat_step = |(root_step >> N);
    end

    always_comb begin
        state_d     = state_q;
        ext_d       = ext_q;
        root_d      = root_q;
        rem_d       = rem_q;
        cnt_d       = cnt_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        out_root_d  = out_root_q;
        out_sat_d   = out_sat_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d    = BUSY;
                    ext_d      = ext_init;
                    root_d     = '0;
                    rem_d      = '0;
                    cnt_d      = cnt_init;
                    in_ready_d = 1'b0;
                end
            end
            BUSY: begin
                ext_d  = ext_q << 2;
                root_d = root_step;
                rem_d  = rem_step;
                cnt_d  = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    // Results are captured from the final step so they are
                    // valid on the same edge that enters DONE.
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    out_sat_d   = sat_step;
                    out_root_d  = sat_step ? '1 : root_step[N-1:0];
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ext_q       <= '0;
            root_q      <= '0;
            rem_q       <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_root_q  <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ext_q       <= ext_d;
            root_q      <= root_d;
            rem_q       <= rem_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_root_q  <= out_root_d;
            out_sat_q   <= out_sat_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_root  = out_root_q;
    assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_isqrt_seq.sv
// -----------------------------------------------------------------------------
// tb_isqrt_seq -- directed bench for isqrt_seq (N=16, POST_SHIFT=8, ITER=20).
// Works for both the fixed-latency build and the ISQRT_EARLY_EXIT_EN build;
// only the expected latency differs between them.
// -----------------------------------------------------------------------------
module tb_isqrt_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_root;
    logic        out_sat;

    int n_checks = 0;
    int n_pass   = 0;

    isqrt_seq #(.N(16), .POST_SHIFT(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_root  (out_root),
        .out_sat   (out_sat)
    );

    // ---- clock ----
    always #5 clk = ~clk;

    // ---- comparison ----
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // ---- reference models ----
    // Edges from accept to out_valid.
    function automatic int exp_latency(input logic [31:0] d);
`ifdef ISQRT_EARLY_EXIT_EN
        logic [39:0] e;
        int p;
        e = {d, 8'h00};
        p = 0;
        for (int i = 0; i < 20; i++) begin
            if (e[2*i +: 2] != 2'b00) p = i;
        end
        return p + 1;
`else
        return 20;
`endif
    endfunction

    // Floor square root of the extended radicand by bit-wise search.
    function automatic longint unsigned ref_sqrt(input logic [31:0] d);
        longint unsigned v, r, t;
        v = longint'(d) << 8;
        r = 0;
        for (int b = 20; b >= 0; b--) begin
            t = r | (64'd1 << b);
            if (t * t <= v) r = t;
        end
        return r;
    endfunction

    // ---- driver: one full transaction ----
    task automatic run(input string tag, input logic [31:0] d,
                       input logic [15:0] exp_root, input logic exp_sat,
                       input int hold);
        int cyc;
        chk({tag, ".in_ready_idle"}, 32'(in_ready), 32'd1);
        in_data  = d;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = $urandom;           // must not affect the running result
        cyc = 0;
        while (!out_valid && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk({tag, ".latency"}, 32'(cyc), 32'(exp_latency(d)));
        chk({tag, ".root"}, 32'(out_root), 32'(exp_root));
        chk({tag, ".sat"}, 32'(out_sat), 32'(exp_sat));
        // Stall in DONE with stray in_valid pulses that must be ignored.
        for (int k = 0; k < hold; k++) begin
            in_valid = k[0];
            in_data  = $urandom;
            @(posedge clk); #1;
            chk({tag, ".hold_valid"}, 32'(out_valid), 32'd1);
            chk({tag, ".hold_in_ready"}, 32'(in_ready), 32'd0);
            chk({tag, ".hold_root"}, 32'(out_root), 32'(exp_root));
            chk({tag, ".hold_sat"}, 32'(out_sat), 32'(exp_sat));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, ".release_valid"}, 32'(out_valid), 32'd0);
        chk({tag, ".release_ready"}, 32'(in_ready), 32'd1);
    endtask

    // ---- directed sequence ----
    initial begin
        logic [31:0]     rd;
        longint unsigned rr;

        // reset
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset.in_ready", 32'(in_ready), 32'd1);
        chk("reset.out_valid", 32'(out_valid), 32'd0);
        chk("reset.out_root", 32'(out_root), 32'd0);
        chk("reset.out_sat", 32'(out_sat), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // exact squares, floor, zero, saturation, round trip
        run("sq_0100", 32'h0000_0100, 16'h0100, 1'b0, 0);
        run("sq_0900", 32'h0000_0900, 16'h0300, 1'b0, 0);
        run("floor_2", 32'h0000_0002, 16'h0016, 1'b0, 0);
        run("zero", 32'h0000_0000, 16'h0000, 1'b0, 0);
        run("sat", 32'hFFFF_FFFF, 16'hFFFF, 1'b1, 0);
        run("roundtrip", 32'h0000_0240, 16'h0180, 1'b0, 5);
        run("one", 32'h0000_0001, 16'h0010, 1'b0, 0);

        // reset in the middle of BUSY (only meaningful with a long run)
        in_data  = 32'h0000_0900;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst.in_ready", 32'(in_ready), 32'd1);
        chk("midrst.out_valid", 32'(out_valid), 32'd0);
        chk("midrst.out_root", 32'(out_root), 32'd0);
        chk("midrst.out_sat", 32'(out_sat), 32'd0);
        run("after_rst", 32'h0000_0100, 16'h0100, 1'b0, 0);

        // random sweep against the floor-sqrt model
        for (int i = 0; i < 8; i++) begin
            case (i % 4)
                0: rd = $urandom;
                1: rd = $urandom_range(0, 32'hFFFF);
                2: rd = $urandom_range(0, 32'hFF_FFFF);
                default: rd = $urandom_range(0, 255);
            endcase
            rr = ref_sqrt(rd);
            if (rr > 64'hFFFF)
                run("rand", rd, 16'hFFFF, 1'b1, 0);
            else
                run("rand", rd, rr[15:0], 1'b0, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
